alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue pipeline stage feeding the integer ALU. Accepts one RV64I instruction
//  plus its register operands and decodes it into the ALU select code and prepared x/y
//  operands. The result is held in a single-entry output register behind a valid/ready
//  handshake. It sits between register read and execute. The ALU stays purely combinational.
// PARAMETERS
//  XLEN  64  datapath width. Only 64 is supported; the W-op rules below assume it.
// PORTS
//  clk        in   1     single clock; every register updates on the rising edge
//  rst        in   1     reset: synchronous, active-high
//  flush      in   1     kill the held entry (branch redirect or trap)
//  in_valid   in   1     instr/operands are valid this cycle
//  in_ready   out  1     stage can accept an instruction this cycle
//  in_instr   in   32    raw instruction word
//  in_pc      in   XLEN  instruction address
//  in_rs1     in   XLEN  rs1 register value
//  in_rs2     in   XLEN  rs2 register value
//  out_valid  out  1     the held entry is valid
//  out_ready  in   1     execute stage consumes the entry this cycle
//  out_x      out  XLEN  ALU x operand, already prepared
//  out_y      out  XLEN  ALU y operand, already prepared
//  out_alusel out  4     ALU select code; uses the `SEL_* macros from const.h
//  out_word   out  1     32-bit op: writeback sign-extends result[31:0]
//  out_rd     out  5     destination register
//  out_wen    out  1     write rd; forced to 0 when rd==0 or the instr is illegal
//  out_illegal out 1     unsupported or malformed encoding
// BEHAVIOUR
//  - Reset: out_valid=0 and every other output register=0. in_ready=1 from the first
//    cycle after reset.
//  - in_ready = !out_valid || out_ready. This is combinational and is the only
//    ready->ready path.
//  - Transfer occurs when in_valid&&in_ready. Decoded fields load on the next edge, so
//    latency is 1 cycle. Back-to-back issue runs at full throughput while out_ready=1.
//  - out_valid update, in priority order:
//    1. rst   -> 0
//    2. flush -> 0; the flush also drops any same-cycle input transfer
//    3. input transfer -> 1
//    4. out_ready -> 0
//    5. otherwise hold
//  - While out_valid && !out_ready, all out_* outputs hold stable.
//  - Decode by opcode:
//    - OP / OP-32 (0110011 / 0111011): x=rs1, y=rs2. funct3/funct7 select the op:
//      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
//    - OP-IMM / OP-IMM-32 (0010011 / 0011011): x=rs1, y=sign-extended imm[11:0].
//      SUBI does not exist, so funct7 applies to shifts only.
//    - LUI: x=0, y=sign-extended {imm[31:12],12'b0}, SEL_ADD.
//    - AUIPC: x=pc, y=sign-extended {imm[31:12],12'b0}, SEL_ADD.
//  - Shift operand masking (the ALU shifts by the full y, so this stage must mask):
//    - 64-bit shifts: y = {58'b0, shamt[5:0]}.
//    - W shifts: y = {59'b0, shamt[4:0]}.
//  - W ops (out_word=1) prepare x:
//    - SRLW: x = zero-extended rs1[31:0].
//    - SRAW: x = sign-extended rs1[31:0].
//    - all others: x is passed unchanged; the low 32 result bits are correct regardless.
//  - Illegal encodings:
//    - any other opcode;
//    - OP funct7 not in {0000000, 0100000};
//    - funct7=0100000 with funct3 other than ADD or SRL;
//    - SLLI/SRLI/SRAI with imm[11:6] not in {000000, 010000};
//    - W ops with funct3 outside {ADD, SLL, SRL};
//    - SLLIW/SRLIW/SRAIW with imm[11:5] not in {0000000, 0100000}, or imm[11:5]=0100000
//      on SLLIW.
//    An illegal instruction still issues with out_illegal=1, out_wen=0, out_alusel=SEL_ADD.
//  - flush while out_valid=0 is harmless. Reset mid-stall discards the held entry.
// STRUCTURE
//  - const.h gains opcode macros: OPC_OP, OPC_OPIMM, OPC_OP32, OPC_OPIMM32, OPC_LUI,
//    OPC_AUIPC. The existing `SEL_* codes are reused unchanged.
//  - One combinational sub-module, alu_opdecode: instr, pc, rs1, rs2 -> x, y, alusel,
//    word, rd, wen, illegal.
//  - The top level holds only the handshake logic and the output register.
// TESTING
//  1. add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle: out_valid=1, x=5, y=7,
//     SEL_ADD, rd=3, wen=1.
//  2. srai x1,x2,63 with rs1=0x8000_0000_0000_0000 -> SEL_SRA, y=63, x unchanged.
//     sraw with rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFE4 -> x=0xFFFF_FFFF_8000_0000,
//     y=4, word=1.
//  3. Stall: out_ready=0 for 3 cycles after a transfer -> in_ready=0, outputs stable.
//     Then raise out_ready -> the next instruction loads on the same edge the held one
//     is consumed.
//  4. flush asserted together with in_valid while holding an entry -> out_valid=0 next
//     cycle, and the incoming instruction is dropped.
//  5. Opcode 0x7F, and OP with funct7=0100000/funct3=XOR -> out_illegal=1, wen=0.
//     addi x0,x0,1 -> wen=0.
//  6. lui x5,0x80000 -> y=0xFFFF_FFFF_8000_0000, x=0.
//     auipc at pc=0x1000 with imm=1 -> x=0x1000, y=0x1000.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the ALU issue stage: opcodes, funct fields,
// ALU select codes and the registered issue entry.
package alu_issue_stage_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        SEL_ADD  = 4'd0,
        SEL_SUB  = 4'd1,
        SEL_SLL  = 4'd2,
        SEL_SLT  = 4'd3,
        SEL_SLTU = 4'd4,
        SEL_XOR  = 4'd5,
        SEL_SRL  = 4'd6,
        SEL_SRA  = 4'd7,
        SEL_OR   = 4'd8,
        SEL_AND  = 4'd9
    } alu_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        alu_sel_e        alusel;
        logic            word;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } issue_entry_t;

    // alt selects SUB/SRA; callers only raise it where the encoding allows it.
    function automatic alu_sel_e f3_to_sel(input logic [2:0] f3, input logic alt);
        alu_sel_e s;
        case (f3)
            F3_ADD:  s = alt ? SEL_SUB : SEL_ADD;
            F3_SLL:  s = SEL_SLL;
            F3_SLT:  s = SEL_SLT;
            F3_SLTU: s = SEL_SLTU;
            F3_XOR:  s = SEL_XOR;
            F3_SRL:  s = alt ? SEL_SRA : SEL_SRL;
            F3_OR:   s = SEL_OR;
            default: s = SEL_AND;
        endcase
        return s;
    endfunction

    function automatic logic is_shift(input alu_sel_e s);
        return (s == SEL_SLL) || (s == SEL_SRL) || (s == SEL_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-side and execute-side handshake bundle of the ALU issue stage.
interface alu_issue_stage_if;
    import alu_issue_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_x;
    logic [XLEN-1:0] out_y;
    logic [3:0]      out_alusel;
    logic            out_word;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_x, out_y, out_alusel, out_word,
               out_rd, out_wen, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_alusel, out_word,
               out_rd, out_wen, out_illegal
    );

endinterface

// File: rtl/alu_issue_stage_opdecode.sv
// Combinational RV64I integer decode: select code, prepared x/y operands,
// destination and legality for OP/OP-IMM/OP-32/OP-IMM-32/LUI/AUIPC.
module alu_opdecode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] x_o,
    output logic [XLEN-1:0] y_o,
    output alu_sel_e        alusel_o,
    output logic            word_o,
    output logic [4:0]      rd_o,
    output logic            wen_o,
    output logic            illegal_o
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [11:0]     imm12;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [5:0]      shamt;
    logic            bad;

    assign opc   = instr_i[6:0];
    assign rd_o  = instr_i[11:7];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm12 = instr_i[31:20];
    assign imm_i = {{(XLEN-12){imm12[11]}}, imm12};
    assign imm_u = {{(XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};

    always_comb begin
        x_o      = rs1_i;
        y_o      = rs2_i;
        alusel_o = SEL_ADD;
        word_o   = 1'b0;
        shamt    = rs2_i[5:0];
        bad      = 1'b0;

        case (opc)
            OPC_OP, OPC_OP32: begin
                word_o   = (opc == OPC_OP32);
                alusel_o = f3_to_sel(f3, f7[5]);
                if (f7 != F7_BASE && f7 != F7_ALT)
                    bad = 1'b1;
                if (f7 == F7_ALT && f3 != F3_ADD && f3 != F3_SRL)
                    bad = 1'b1;
                if (word_o && f3 != F3_ADD && f3 != F3_SLL && f3 != F3_SRL)
                    bad = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                word_o   = (opc == OPC_OPIMM32);
                y_o      = imm_i;
                shamt    = imm12[5:0];
                // imm[10] only distinguishes SRAI/SRAIW; there is no SUBI.
                alusel_o = f3_to_sel(f3, (f3 == F3_SRL) && imm12[10]);
                if (f3 == F3_SLL || f3 == F3_SRL) begin
                    if (word_o) begin
                        if (imm12[11:5] != F7_BASE && imm12[11:5] != F7_ALT)
                            bad = 1'b1;
                        if (f3 == F3_SLL && imm12[11:5] == F7_ALT)
                            bad = 1'b1;
                    end else if (imm12[11:6] != 6'b000000 && imm12[11:6] != 6'b010000) begin
                        bad = 1'b1;
                    end
                end
                if (word_o && f3 != F3_ADD && f3 != F3_SLL && f3 != F3_SRL)
                    bad = 1'b1;
            end
            OPC_LUI: begin
                x_o = '0;
                y_o = imm_u;
            end
            OPC_AUIPC: begin
                x_o = pc_i;
                y_o = imm_u;
            end
            default: bad = 1'b1;
        endcase

        // The ALU shifts by the whole y, so only the legal shamt bits may reach it.
        if (is_shift(alusel_o))
            y_o = word_o ? XLEN'(shamt[4:0]) : XLEN'(shamt);

        if (word_o && alusel_o == SEL_SRL)
            x_o = XLEN'(rs1_i[31:0]);
        else if (word_o && alusel_o == SEL_SRA)
            x_o = {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]};

        if (bad)
            alusel_o = SEL_ADD;
    end

    assign illegal_o = bad;
    assign wen_o     = !bad && (rd_o != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per transfer into a single-entry
// output register behind a valid/ready handshake.
module alu_issue_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);
    import alu_issue_stage_pkg::*;

    issue_entry_t    entry_q, entry_d;
    issue_entry_t    dec;
    logic            valid_q, valid_d;
    logic            xfer;

    logic [XLEN-1:0] dec_x, dec_y;
    alu_sel_e        dec_sel;
    logic            dec_word, dec_wen, dec_illegal;
    logic [4:0]      dec_rd;

    alu_opdecode u_opdecode (
        .instr_i   (bus.in_instr),
        .pc_i      (bus.in_pc),
        .rs1_i     (bus.in_rs1),
        .rs2_i     (bus.in_rs2),
        .x_o       (dec_x),
        .y_o       (dec_y),
        .alusel_o  (dec_sel),
        .word_o    (dec_word),
        .rd_o      (dec_rd),
        .wen_o     (dec_wen),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        dec         = '0;
        dec.x       = dec_x;
        dec.y       = dec_y;
        dec.alusel  = dec_sel;
        dec.word    = dec_word;
        dec.rd      = dec_rd;
        dec.wen     = dec_wen;
        dec.illegal = dec_illegal;
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;

    // Flush outranks a same-cycle transfer, which is then dropped.
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
            entry_d = dec;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_x       = entry_q.x;
    assign bus.out_y       = entry_q.y;
    assign bus.out_alusel  = entry_q.alusel;
    assign bus.out_word    = entry_q.word;
    assign bus.out_rd      = entry_q.rd;
    assign bus.out_wen     = entry_q.wen;
    assign bus.out_illegal = entry_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus randomized RV64I
// traffic, expected entries derived from mnemonic semantics.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    typedef struct {
        logic [63:0] x;
        logic [63:0] y;
        alu_sel_e    sel;
        logic        word;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    localparam logic [2:0] RF3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    localparam logic [6:0] RF7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    localparam alu_sel_e   RSEL[10] = '{SEL_ADD, SEL_SUB, SEL_SLL, SEL_SLT, SEL_SLTU,
                                        SEL_XOR, SEL_SRL, SEL_SRA, SEL_OR, SEL_AND};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic mon_en = 1'b0;
    int unsigned passed = 0;
    int unsigned total = 0;
    exp_t exp_q[$];

    alu_issue_stage_if bus();

    alu_issue_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [63:0] x, input logic [63:0] y, input alu_sel_e s,
                                input logic w, input logic [4:0] rd, input logic ill);
        exp_t e;
        e.x = x; e.y = y; e.sel = s; e.word = w; e.rd = rd; e.ill = ill;
        e.wen = !ill && (rd != 5'd0);
        return e;
    endfunction

    function automatic logic [63:0] sx32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] sx12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

    // Drive one cycle starting at posedge+1; the entry is queued at the edge it loads on.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] r1, input logic [63:0] r2, input exp_t e,
                         input logic ordy, input logic fl, input logic r, output logic acc);
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
        bus.in_rs1 = r1; bus.in_rs2 = r2; bus.out_ready = ordy;
        flush = fl; rst = r;
        acc = v && !fl && !r && (exp_q.size() == 0 || ordy);
        @(posedge clk);
        if (acc) exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic fl, input logic r);
        logic acc;
        exp_t z;
        z = mk('0, '0, SEL_ADD, 1'b0, 5'd0, 1'b0);
        cycle(1'b0, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              z, ordy, fl, r, acc);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] r1,
                         input logic [63:0] r2, input exp_t e, input logic rand_ctl);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++)
            cycle(1'b1, ins, pc, r1, r2, e,
                  rand_ctl ? ($urandom_range(0, 3) != 0) : 1'b1,
                  rand_ctl ? ($urandom_range(0, 19) == 0) : 1'b0, 1'b0, acc);
        if (!acc) begin
            total++;
            $display("FAIL issue_timeout: instr 0x%08h never accepted", ins);
        end
    endtask

    task automatic check_reset();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        check("rst_x", bus.out_x, 64'd0);
        check("rst_y", bus.out_y, 64'd0);
        check("rst_sel", 64'(bus.out_alusel), 64'd0);
        check("rst_misc", 64'({bus.out_word, bus.out_rd, bus.out_wen, bus.out_illegal}), 64'd0);
    endtask

    task automatic gen(input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] pc,
                       output logic [31:0] ins, output exp_t e);
        int unsigned cls, k, j;
        logic [4:0] rd, r1f, r2f;
        logic [11:0] imm;
        logic [19:0] u;
        logic [5:0] sh;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [63:0] xw;
        cls = $urandom_range(0, 8);
        rd = 5'($urandom); r1f = 5'($urandom); r2f = 5'($urandom);
        imm = 12'($urandom); u = 20'($urandom); sh = 6'($urandom);
        case (cls)
            0, 1: begin
                k = $urandom_range(0, 9);
                ins = {RF7[k], r2f, r1f, RF3[k], rd, 7'b0110011};
                e = mk(rs1, is_shift(RSEL[k]) ? (rs2 & 64'd63) : rs2, RSEL[k], 1'b0, rd, 1'b0);
            end
            2: begin
                j = $urandom_range(0, 4);
                k = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 2 : (j == 3) ? 6 : 7;
                xw = (k == 6) ? {32'd0, rs1[31:0]} : (k == 7) ? sx32(rs1) : rs1;
                ins = {RF7[k], r2f, r1f, RF3[k], rd, 7'b0111011};
                e = mk(xw, is_shift(RSEL[k]) ? (rs2 & 64'd31) : rs2, RSEL[k], 1'b1, rd, 1'b0);
            end
            3: begin
                j = $urandom_range(0, 5);
                k = (j == 0) ? 0 : (j == 1) ? 3 : (j == 2) ? 4 : (j == 3) ? 5 : (j == 4) ? 8 : 9;
                ins = {imm, r1f, RF3[k], rd, 7'b0010011};
                e = mk(rs1, sx12(imm), RSEL[k], 1'b0, rd, 1'b0);
            end
            4: begin
                j = $urandom_range(0, 2);
                k = (j == 0) ? 2 : (j == 1) ? 6 : 7;
                ins = {RF7[k][6:1], sh, r1f, RF3[k], rd, 7'b0010011};
                e = mk(rs1, {58'd0, sh}, RSEL[k], 1'b0, rd, 1'b0);
            end
            5: begin
                j = $urandom_range(0, 3);
                if (j == 0) begin
                    ins = {imm, r1f, 3'd0, rd, 7'b0011011};
                    e = mk(rs1, sx12(imm), SEL_ADD, 1'b1, rd, 1'b0);
                end else begin
                    k = (j == 1) ? 2 : (j == 2) ? 6 : 7;
                    xw = (k == 6) ? {32'd0, rs1[31:0]} : (k == 7) ? sx32(rs1) : rs1;
                    ins = {RF7[k], sh[4:0], r1f, RF3[k], rd, 7'b0011011};
                    e = mk(xw, {59'd0, sh[4:0]}, RSEL[k], 1'b1, rd, 1'b0);
                end
            end
            6: begin
                ins = {u, rd, 7'b0110111};
                e = mk(64'd0, sx32({32'd0, u, 12'd0}), SEL_ADD, 1'b0, rd, 1'b0);
            end
            7: begin
                ins = {u, rd, 7'b0010111};
                e = mk(pc, sx32({32'd0, u, 12'd0}), SEL_ADD, 1'b0, rd, 1'b0);
            end
            default: begin
                j = $urandom_range(0, 6);
                f3 = 3'($urandom);
                case (j)
                    0: begin
                        do opc = 7'($urandom);
                        while (opc == 7'h33 || opc == 7'h13 || opc == 7'h3B ||
                               opc == 7'h1B || opc == 7'h37 || opc == 7'h17);
                        ins = {imm, r1f, f3, rd, opc};
                    end
                    1: begin
                        do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                        ins = {f7, r2f, r1f, f3, rd, ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h3B};
                    end
                    2: begin
                        do f3 = 3'($urandom); while (f3 == 3'd0 || f3 == 3'd5);
                        ins = {7'h20, r2f, r1f, f3, rd, ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h3B};
                    end
                    3: begin
                        do f3 = 3'($urandom); while (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
                        ins = {($urandom_range(0, 1) != 0) ? {7'h00, r2f} : imm, r1f, f3, rd,
                               ($urandom_range(0, 1) != 0) ? 7'h3B : 7'h1B};
                    end
                    4: begin
                        do f7 = 7'($urandom); while (f7[6:1] == 6'h00 || f7[6:1] == 6'h10);
                        ins = {f7[6:1], sh, r1f, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, rd, 7'h13};
                    end
                    5: ins = {7'h20, sh[4:0], r1f, 3'd1, rd, 7'h1B};
                    default: begin
                        do f7 = 7'($urandom); while (f7 == 7'h00 || f7 == 7'h20);
                        ins = {f7, sh[4:0], r1f, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5, rd, 7'h1B};
                    end
                endcase
                e = mk(64'd0, 64'd0, SEL_ADD, 1'b0, rd, 1'b1);
            end
        endcase
    endtask

    // Monitor: compares the held entry every cycle it is presented.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() == 0 || bus.out_ready));
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0 && bus.out_valid) begin
                check("alusel", 64'(bus.out_alusel), 64'(exp_q[0].sel));
                check("rd", 64'(bus.out_rd), 64'(exp_q[0].rd));
                check("wen", 64'(bus.out_wen), 64'(exp_q[0].wen));
                check("illegal", 64'(bus.out_illegal), 64'(exp_q[0].ill));
                if (!exp_q[0].ill) begin
                    check("x", bus.out_x, exp_q[0].x);
                    check("y", bus.out_y, exp_q[0].y);
                    check("word", 64'(bus.out_word), 64'(exp_q[0].word));
                end
            end
            if (rst) exp_q.delete();
            else if (exp_q.size() != 0 && (bus.out_ready || flush)) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic acc;
        logic [31:0] ins;
        logic [63:0] r1, r2, pc;
        exp_t e;

        idle(1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 1'b1);
        check_reset();
        mon_en = 1'b1;

        issue(32'h002081B3, 64'h0, 64'd5, 64'd7, mk(64'd5, 64'd7, SEL_ADD, 1'b0, 5'd3, 1'b0), 1'b0);
        issue(32'h43F15093, 64'h0, 64'h8000_0000_0000_0000, 64'd0,
              mk(64'h8000_0000_0000_0000, 64'd63, SEL_SRA, 1'b0, 5'd1, 1'b0), 1'b0);
        issue(32'h4020D23B, 64'h0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFE4,
              mk(64'hFFFF_FFFF_8000_0000, 64'd4, SEL_SRA, 1'b1, 5'd4, 1'b0), 1'b0);
        issue(32'h000002FF, 64'h0, 64'd1, 64'd2, mk(64'd0, 64'd0, SEL_ADD, 1'b0, 5'd5, 1'b1), 1'b0);
        issue(32'h4020C333, 64'h0, 64'd1, 64'd2, mk(64'd0, 64'd0, SEL_ADD, 1'b0, 5'd6, 1'b1), 1'b0);
        issue(32'h00100013, 64'h0, 64'd0, 64'd9, mk(64'd0, 64'd1, SEL_ADD, 1'b0, 5'd0, 1'b0), 1'b0);
        issue(32'h800002B7, 64'h0, 64'd3, 64'd4,
              mk(64'd0, 64'hFFFF_FFFF_8000_0000, SEL_ADD, 1'b0, 5'd5, 1'b0), 1'b0);
        issue(32'h00001397, 64'h1000, 64'd3, 64'd4,
              mk(64'h1000, 64'h1000, SEL_ADD, 1'b0, 5'd7, 1'b0), 1'b0);

        // Stall for three cycles, then release: next instruction loads as the held one leaves.
        cycle(1'b1, 32'h002081B3, 64'h0, 64'd11, 64'd12,
              mk(64'd11, 64'd12, SEL_ADD, 1'b0, 5'd3, 1'b0), 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h4020C333, 64'h0, 64'd1, 64'd2,
                  mk(64'd0, 64'd0, SEL_ADD, 1'b0, 5'd6, 1'b1), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h4020C333, 64'h0, 64'd1, 64'd2,
              mk(64'd0, 64'd0, SEL_ADD, 1'b0, 5'd6, 1'b1), 1'b1, 1'b0, 1'b0, acc);
        check("stall_release_accept", 64'(acc), 64'd1);
        idle(1'b1, 1'b0, 1'b0);

        // Flush with a held entry and a same-cycle input.
        cycle(1'b1, 32'h00100013, 64'h0, 64'd0, 64'd0,
              mk(64'd0, 64'd1, SEL_ADD, 1'b0, 5'd0, 1'b0), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h002081B3, 64'h0, 64'd1, 64'd1,
              mk(64'd1, 64'd1, SEL_ADD, 1'b0, 5'd3, 1'b0), 1'b0, 1'b1, 1'b0, acc);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        idle(1'b0, 1'b1, 1'b0);

        // Reset while stalled discards the held entry.
        cycle(1'b1, 32'h002081B3, 64'h0, 64'd1, 64'd1,
              mk(64'd1, 64'd1, SEL_ADD, 1'b0, 5'd3, 1'b0), 1'b0, 1'b0, 1'b0, acc);
        idle(1'b0, 1'b0, 1'b1);
        check_reset();

        for (int n = 0; n < 400; n++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            pc = {$urandom, $urandom};
            gen(r1, r2, pc, ins, e);
            issue(ins, pc, r1, r2, e, 1'b1);
            if ($urandom_range(0, 4) == 0)
                idle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        for (int i = 0; i < 8 && exp_q.size() != 0; i++)
            idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
